// File: rtl/io_input_bank.sv
// io_input_bank: memory-mapped bank of synchronised, debounced input ports
// with sticky W1C change flags, interrupt enables and a level interrupt.
module io_input_bank #(
   parameter int         NUM_PORTS    = 2,
   parameter int         DATA_W       = 32,
   parameter logic [7:0] BASE_OFF     = 8'hC0,
   parameter int         DEBOUNCE_CYC = 4
) (
   input  logic                        io_clk,
   input  logic                        reset,
   input  logic [31:0]                 addr,
   input  logic                        we,
   input  logic [31:0]                 wdata,
   input  logic [NUM_PORTS*DATA_W-1:0] in_port,
   output logic [31:0]                 io_read_data,
   output logic                        irq
);
   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYC == 0 ? 0 : DEBOUNCE_CYC - 1);
   logic [DATA_W-1:0] sync1_q [NUM_PORTS];
   logic [DATA_W-1:0] sync2_q [NUM_PORTS];
   logic [DATA_W-1:0] cand_q [NUM_PORTS], cand_d [NUM_PORTS];
   logic [DATA_W-1:0] stable_q [NUM_PORTS], stable_d [NUM_PORTS];
   logic [7:0] cnt_q [NUM_PORTS], cnt_d [NUM_PORTS];
   logic [NUM_PORTS-1:0] upd, status_q, status_d, irq_en_q, irq_en_d;
   logic [7:0] off;
   logic [5:0] idx;
   logic unused;
   assign off = addr[7:0] - BASE_OFF;
   assign idx = off[7:2];
   assign unused = ^{addr[31:8], off[1:0], wdata[31:NUM_PORTS]};
   always_comb begin
      upd = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand_d[i] = cand_q[i];
         stable_d[i] = stable_q[i];
         cnt_d[i] = '0;
         if (DEBOUNCE_CYC == 0) stable_d[i] = sync2_q[i];
         else if (sync2_q[i] != cand_q[i]) cand_d[i] = sync2_q[i];
         else if (cand_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) stable_d[i] = cand_q[i];
            else cnt_d[i] = cnt_q[i] + 8'd1;
         end
         upd[i] = stable_d[i] != stable_q[i];
      end
   end
   // a fresh change on the same edge as a W1C clear keeps its flag
   assign status_d = (status_q & ~((we && idx == 6'd8) ? wdata[NUM_PORTS-1:0] : '0)) | upd;
   assign irq_en_d = (we && idx == 6'd9) ? wdata[NUM_PORTS-1:0] : irq_en_q;
   always_ff @(posedge io_clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            sync1_q[i] <= '0;
            sync2_q[i] <= '0;
            cand_q[i] <= '0;
            stable_q[i] <= '0;
            cnt_q[i] <= '0;
         end
         status_q <= '0;
         irq_en_q <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            sync1_q[i] <= in_port[i*DATA_W +: DATA_W];
            sync2_q[i] <= sync1_q[i];
            cand_q[i] <= cand_d[i];
            stable_q[i] <= stable_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         status_q <= status_d;
         irq_en_q <= irq_en_d;
      end
   end
   always_comb begin
      io_read_data = '0;
      for (int i = 0; i < NUM_PORTS; i++) io_read_data = (idx == 6'(i)) ? 32'(stable_q[i]) : io_read_data;
      io_read_data = (idx == 6'd8) ? 32'(status_q) : (idx == 6'd9) ? 32'(irq_en_q) : io_read_data;
   end
   assign irq = |(status_q & irq_en_q);
endmodule

// File: tb/tb_io_input_bank.sv
// tb_io_input_bank: scoreboard bench driving a debounced and a bypass instance
// with shared stimulus against a sliding-window reference model.
module tb_io_input_bank;
   localparam int N = 2;
   localparam int W = 32;
   localparam logic [7:0] B = 8'hC0;

   typedef struct packed {
      logic [31:0] r0;
      logic [31:0] r1;
      logic        q0;
      logic        q1;
      logic [7:0]  a;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [N*W-1:0] in_port = '0;
   logic [31:0] rd0, rd1;
   logic irq0, irq1;
   logic [31:0] cur0 = '0, cur1 = '0;
   exp_t sb[$];
   int vectors = 0, miscompares = 0;

   int dcyc [2] = '{4, 0};
   logic [31:0] hist [2][N][5];
   logic [31:0] m_p1 [N], m_p2 [N];
   logic [31:0] m_st [2][N];
   logic [N-1:0] m_status [2], m_en [2];

   io_input_bank #(.NUM_PORTS(N), .DATA_W(W), .BASE_OFF(B), .DEBOUNCE_CYC(4)) u_deb (
      .io_clk(clk), .reset(rst), .addr(addr), .we(we), .wdata(wdata),
      .in_port(in_port), .io_read_data(rd0), .irq(irq0));
   io_input_bank #(.NUM_PORTS(N), .DATA_W(W), .BASE_OFF(B), .DEBOUNCE_CYC(0)) u_byp (
      .io_clk(clk), .reset(rst), .addr(addr), .we(we), .wdata(wdata),
      .in_port(in_port), .io_read_data(rd1), .irq(irq1));

   function automatic int word_of(input logic [31:0] a);
      int off;
      off = int'(a[7:0]) - int'(B);
      return (off >= 0 && off < 40) ? off / 4 : -1;
   endfunction

   function automatic logic [31:0] exp_rd(input int i);
      int wd;
      wd = word_of(addr);
      if (wd >= 0 && wd < N) return m_st[i][wd];
      if (wd == 8) return 32'(m_status[i]);
      if (wd == 9) return 32'(m_en[i]);
      return 32'h0;
   endfunction

   // A port accepts a value once the synchronised input has shown it for
   // DEBOUNCE+1 consecutive edges and it differs from the accepted value.
   task automatic model_edge();
      logic [N-1:0] upd, clr;
      logic same;
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < N; p++) begin
               m_st[i][p] = '0;
               for (int j = 0; j < 5; j++) hist[i][p][j] = '0;
            end
            m_status[i] = '0;
            m_en[i] = '0;
         end
         for (int p = 0; p < N; p++) begin
            m_p1[p] = '0;
            m_p2[p] = '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            upd = '0;
            for (int p = 0; p < N; p++) begin
               for (int j = 4; j > 0; j--) hist[i][p][j] = hist[i][p][j-1];
               hist[i][p][0] = m_p2[p];
               same = 1'b1;
               for (int j = 1; j <= dcyc[i]; j++) if (hist[i][p][j] != hist[i][p][0]) same = 1'b0;
               if (same && hist[i][p][0] != m_st[i][p]) begin
                  m_st[i][p] = hist[i][p][0];
                  upd[p] = 1'b1;
               end
            end
            clr = (we && word_of(addr) == 8) ? wdata[N-1:0] : '0;
            m_status[i] = (m_status[i] & ~clr) | upd;
            if (we && word_of(addr) == 9) m_en[i] = wdata[N-1:0];
         end
         for (int p = 0; p < N; p++) begin
            m_p2[p] = m_p1[p];
            m_p1[p] = in_port[p*W +: W];
         end
      end
   endtask

   task automatic cyc(input logic r, input logic [31:0] a, input logic w, input logic [31:0] wd);
      exp_t e;
      rst = r;
      in_port = {cur1, cur0};
      addr = a;
      we = w;
      wdata = wd;
      e.r0 = exp_rd(0);
      e.r1 = exp_rd(1);
      e.q0 = |(m_status[0] & m_en[0]);
      e.q1 = |(m_status[1] & m_en[1]);
      e.a = a[7:0];
      sb.push_back(e);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic step(input logic [7:0] a, input logic w = 1'b0, input logic [31:0] wd = 32'h0);
      cyc(1'b0, {24'($urandom), a}, w, wd);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         vectors += 2;
         if ({rd0, irq0} !== {e.r0, e.q0}) begin
            miscompares++;
            $display("FAIL deb addr=%h rd=%h irq=%b expected rd=%h irq=%b", e.a, rd0, irq0, e.r0, e.q0);
         end
         if ({rd1, irq1} !== {e.r1, e.q1}) begin
            miscompares++;
            $display("FAIL byp addr=%h rd=%h irq=%b expected rd=%h irq=%b", e.a, rd1, irq1, e.r1, e.q1);
         end
      end
   end

   initial begin
      logic [7:0] amap [7];
      amap = '{B, B + 8'h04, B + 8'h08, B + 8'h20, B + 8'h24, B + 8'h28, 8'h10};
      repeat (2) begin
         @(posedge clk);
         model_edge();
      end
      #1;
      cyc(1'b1, {24'h0, B}, 1'b0, 32'h0);
      cyc(1'b1, {24'h0, B + 8'h04}, 1'b0, 32'h0);
      cyc(1'b1, {24'h0, B + 8'h20}, 1'b0, 32'h0);
      cyc(1'b1, {24'h0, B + 8'h24}, 1'b0, 32'h0);
      cur0 = 32'hA5A5_0001;
      repeat (9) step(B);
      step(B + 8'h20);
      cur1 = 32'h1;
      repeat (3) step(B + 8'h04);
      cur1 = 32'h0;
      repeat (6) step(B + 8'h04);
      step(B + 8'h20);
      cur1 = 32'h84;
      repeat (8) step(B + 8'h04);
      step(B + 8'h08);
      step(B + 8'h28);
      step(8'h10);
      step(B + 8'h1C);
      step(B + 8'h24, 1'b1, 32'h3);
      step(B + 8'h24);
      step(B + 8'h20, 1'b1, 32'h3);
      cur0 = 32'h1234;
      repeat (8) step(B + 8'h20);
      step(B + 8'h20, 1'b1, 32'h1);
      repeat (2) step(B + 8'h20);
      cur0 = 32'h55;
      repeat (6) step(B + 8'h20);
      step(B + 8'h20, 1'b1, 32'h1);
      repeat (3) step(B + 8'h20);
      cur0 = 32'h7;
      repeat (5) step(B);
      cyc(1'b1, {24'h0, B + 8'h20}, 1'b0, 32'h0);
      cyc(1'b1, {24'h0, B}, 1'b0, 32'h0);
      repeat (9) step(B + 8'h20);
      for (int n = 0; n < 400; n++) begin
         logic [7:0] a;
         if ($urandom_range(0, 9) == 0) cur0 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         if ($urandom_range(0, 9) == 0) cur1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         a = amap[$urandom_range(0, 6)] | 8'($urandom_range(0, 3));
         if ($urandom_range(0, 99) == 0) cyc(1'b1, {24'($urandom), a}, 1'b0, 32'h0);
         else step(a, $urandom_range(0, 4) == 0, $urandom);
      end
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain pending=%0d expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
